tt_pin_exerciser: RTL

TT_PIN_EXERCISER -- requirements
Module: tt_pin_exerciser

---
 rtl/tt_pin_exerciser_if.sv | 25 ++
 rtl/tt_pin_exerciser.sv | 130 +++++++++++++
 2 files changed

// File: rtl/tt_pin_exerciser_if.sv
// Pin bundle between the exerciser and a TinyTapeout-style DUT.
// The master drives stimulus and DUT control, and the slave returns the DUT outputs.
interface tt_pin_exerciser_if #(
   parameter int IO_W = 8
);
   logic [IO_W-1:0] drive_ui;
   logic [IO_W-1:0] drive_uio;
   logic            dut_ena;
   logic            dut_rst_n;
   logic [IO_W-1:0] obs_uo;
   logic [IO_W-1:0] obs_uio;
   logic [IO_W-1:0] obs_uio_oe;

   modport master (
      output drive_ui, drive_uio,
      output dut_ena, dut_rst_n,
      input  obs_uo, obs_uio, obs_uio_oe
   );

   modport slave (
      input  drive_ui, drive_uio,
      input  dut_ena, dut_rst_n,
      output obs_uo, obs_uio, obs_uio_oe
   );
endinterface

// File: rtl/tt_pin_exerciser.sv
// Drives LFSR vectors into a TinyTapeout DUT after a reset phase.
// A MISR compacts the DUT outputs, and the result is compared with a golden signature.
module tt_pin_exerciser #(
   parameter int                  IO_W      = 8,
   parameter int                  SIG_W     = 32,
   parameter logic [SIG_W-1:0]    SIG_POLY  = 32'h04C11DB7,
   parameter logic [2*IO_W-1:0]   LFSR_POLY = 16'hB400,
   parameter logic [2*IO_W-1:0]   SEED      = 16'h0001,
   parameter int                  LAT       = 1,
   parameter int                  RST_CYC   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [15:0]      vec_count,
   input  logic [SIG_W-1:0] expect_sig,
   tt_pin_exerciser_if.master pins,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature
);
   localparam int LW = 2 * IO_W;
   localparam logic [LW-1:0] SEED_V =
      (SEED == '0) ? LW'(1) : SEED;
   localparam logic [16:0] LAT_V    = 17'(LAT);
   localparam logic [15:0] RST_LAST = 16'(RST_CYC - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_DRST  = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]       state;
   logic [LW-1:0]    lfsr;
   logic [LW-1:0]    lfsr_nx;
   logic [SIG_W-1:0] sig;
   logic [SIG_W-1:0] sig_nx;
   logic [SIG_W-1:0] exp_q;
   logic [15:0]      n_q;
   logic [15:0]      rcnt;
   logic [16:0]      tc;
   logic [LW-1:0]    obs;
   logic             go;
   logic             cap;
   logic             last_vec;
   logic             last_cap;
   logic             active;

   always_comb begin
      go  = start &&
            (state == S_IDLE || state == S_DONE);
      obs = {pins.obs_uio & pins.obs_uio_oe,
             pins.obs_uo};
      sig_nx = {sig[SIG_W-2:0], 1'b0}
             ^ (sig[SIG_W-1] ? SIG_POLY : '0)
             ^ SIG_W'(obs);
      lfsr_nx = (lfsr >> 1)
              ^ (lfsr[0] ? LFSR_POLY : '0);
      // tc counts cycles from the first vector
      last_vec = tc == {1'b0, n_q} - 17'd1;
      last_cap = tc == {1'b0, n_q} + LAT_V - 17'd1;
      active   = state == S_RUN ||
                 state == S_DRAIN;
      cap      = active && tc >= LAT_V;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         lfsr  <= SEED_V;
         sig   <= '0;
         exp_q <= '0;
         n_q   <= '0;
         rcnt  <= '0;
         tc    <= '0;
      end else if (abort) begin
         state <= S_IDLE;
         sig   <= '0;
         rcnt  <= '0;
         tc    <= '0;
      end else if (go) begin
         state <= S_DRST;
         n_q   <= vec_count;
         exp_q <= expect_sig;
         lfsr  <= SEED_V;
         sig   <= '0;
         rcnt  <= '0;
         tc    <= '0;
      end else begin
         if (cap)
            sig <= sig_nx;
         unique case (1'b1)
            state == S_DRST: begin
               rcnt <= rcnt + 16'd1;
               if (rcnt == RST_LAST)
                  state <= (n_q == 16'd0) ?
                           S_DONE : S_RUN;
            end
            state == S_RUN: begin
               tc <= tc + 17'd1;
               // final vector stays on the bus
               if (!last_vec)
                  lfsr <= lfsr_nx;
               else
                  state <= (LAT == 0) ?
                           S_DONE : S_DRAIN;
            end
            state == S_DRAIN: begin
               tc <= tc + 17'd1;
               if (last_cap)
                  state <= S_DONE;
            end
            default: ;
         endcase
      end
   end

   assign busy      = state == S_DRST || active;
   assign done      = state == S_DONE;
   assign pass      = done && (sig == exp_q);
   assign signature = sig;

   assign pins.dut_ena   = state != S_IDLE;
   assign pins.dut_rst_n = active || done;
   assign {pins.drive_uio, pins.drive_ui} =
      (active || done) ? lfsr : '0;
endmodule
